// File: rtl/mul_div_if.sv
// rtl/mul_div_if.sv - request/operand/result bundle for mul_div_unit
interface mul_div_if #(parameter int DATA_WIDTH = 32) ();
   logic                  start;
   logic [2:0]            op;
   logic [DATA_WIDTH-1:0] A;
   logic [DATA_WIDTH-1:0] B;
   logic                  abort;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] result;

   modport master (output start, op, A, B, abort, input busy, done, result);
   modport slave  (input start, op, A, B, abort, output busy, done, result);
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide, one radix-2 step per cycle
module mul_div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input logic      clk,
   input logic      rst_n,
   mul_div_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [2:0]     op_q;
   logic [W-1:0]   opnd;
   logic [2*W-1:0] acc;
   logic           neg;
   logic           div_zero;
   logic           done_q;
   logic [W-1:0]   result_q;

   logic           a_signed, b_signed, sa, sb;
   logic [W-1:0]   mag_a, mag_b;

   always_comb begin
      a_signed = (bus.op == 3'b001) || (bus.op == 3'b010) ||
                 (bus.op == 3'b100) || (bus.op == 3'b110);
      b_signed = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
      sa       = a_signed & bus.A[W-1];
      sb       = b_signed & bus.B[W-1];
      mag_a    = sa ? -bus.A : bus.A;
      mag_b    = sb ? -bus.B : bus.B;
   end

   // acc is {product} for multiply and {remainder, quotient/dividend} for divide
   logic [W:0]     mul_sum, shifted;
   logic [2*W-1:0] acc_next;

   always_comb begin
      mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
      shifted = acc[2*W-1:W-1];
      acc_next = {mul_sum, acc[W-1:1]};
      if (op_q[2]) begin
         if (shifted >= {1'b0, opnd}) begin
            acc_next = {shifted[W-1:0] - opnd, acc[W-2:0], 1'b1};
         end else begin
            acc_next = {shifted[W-1:0], acc[W-2:0], 1'b0};
         end
      end
   end

   logic [2*W-1:0] prod;
   logic [W-1:0]   quo, rem, fin;

   always_comb begin
      prod = neg ? -acc : acc;
      // a zero divisor must yield all-ones regardless of the dividend sign
      quo  = div_zero ? {W{1'b1}} : (neg ? -acc[W-1:0] : acc[W-1:0]);
      rem  = neg ? -acc[2*W-1:W] : acc[2*W-1:W];
      case (op_q)
         3'b000:                 fin = prod[W-1:0];
         3'b001, 3'b010, 3'b011: fin = prod[2*W-1:W];
         3'b100, 3'b101:         fin = quo;
         default:                fin = rem;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         op_q     <= '0;
         opnd     <= '0;
         acc      <= '0;
         neg      <= 1'b0;
         div_zero <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state    <= CALC;
                  cnt      <= '0;
                  op_q     <= bus.op;
                  neg      <= (bus.op[2] & bus.op[1]) ? sa : (sa ^ sb);
                  div_zero <= (bus.B == '0);
                  acc      <= {{W{1'b0}}, (bus.op[2] ? mag_a : mag_b)};
                  opnd     <= bus.op[2] ? mag_b : mag_a;
               end
            end
            CALC: begin
               if (bus.abort) begin
                  state <= IDLE;
               end else begin
                  acc <= acc_next;
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(W-1)) state <= FINISH;
               end
            end
            FINISH: begin
               state <= IDLE;
               if (!bus.abort) begin
                  result_q <= fin;
                  done_q   <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy   = (state != IDLE);
   assign bus.done   = done_q;
   assign bus.result = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed scoreboard bench for mul_div_unit
module tb_mul_div_unit;
   logic clk = 1'b0;
   logic rst_n;

   mul_div_if #(.DATA_WIDTH(32)) bus ();
   mul_div_unit #(.DATA_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] sb_q[$];

   task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // called at a negedge with the unit idle; returns at the negedge of the done cycle
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
      int          cyc;
      int          busy_cnt;
      logic [31:0] e;
      bus.start = 1'b1;
      bus.op    = o;
      bus.A     = a;
      bus.B     = b;
      sb_q.push_back(exp);
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.A     = $urandom;
      bus.B     = $urandom;
      bus.op    = 3'($urandom);
      cyc       = 1;
      busy_cnt  = 0;
      while (!bus.done && cyc < 60) begin
         if (bus.busy) busy_cnt++;
         @(negedge clk);
         cyc++;
      end
      check(32'(bus.done), 32'd1, {tag, "_done"});
      check(32'(cyc), 32'd34, {tag, "_latency"});
      check(32'(busy_cnt), 32'd33, {tag, "_busy_cycles"});
      check(32'(bus.busy), 32'd0, {tag, "_busy_at_done"});
      e = sb_q.pop_front();
      check(bus.result, e, tag);
   endtask

   initial begin
      int  seen_done;
      int  seen_busy;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.op    = 3'b000;
      bus.A     = '0;
      bus.B     = '0;
      repeat (2) @(negedge clk);
      check(32'(bus.busy), 32'd0, "reset_busy");
      check(32'(bus.done), 32'd0, "reset_done");
      check(bus.result, 32'd0, "reset_result");
      rst_n = 1'b1;

      run_op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7_m3");
      run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_ones");
      run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_ones");
      run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_ones");
      run_op(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_m7_2");
      run_op(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem_m7_2");
      run_op(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, "divu_by0");
      run_op(3'b111, 32'd5,        32'd0,        32'd5,        "remu_by0");
      run_op(3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, "div_neg_by0");
      run_op(3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, "rem_neg_by0");
      run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
      run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf");
      run_op(3'b111, 32'd100,      32'd7,        32'd2,        "remu_100_7");
      run_op(3'b101, 32'd100,      32'd7,        32'd14,       "divu_100_7");

      // ignored start while busy, then abort mid-CALC
      bus.start = 1'b1;
      bus.op    = 3'b100;
      bus.A     = 32'd1000;
      bus.B     = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      seen_done = 0;
      for (int c = 1; c < 10; c++) begin
         if (c == 5) begin
            bus.start = 1'b1;
            bus.A     = 32'd77;
            bus.B     = 32'd5;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         if (bus.done) seen_done++;
      end
      bus.start = 1'b0;
      check(32'(bus.busy), 32'd1, "abort_busy_before");
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check(32'(bus.busy), 32'd0, "abort_busy_after");
      check(32'(bus.done), 32'd0, "abort_done");
      check(bus.result, 32'd14, "abort_result_held");
      seen_busy = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.done) seen_done++;
         if (bus.busy) seen_busy++;
      end
      check(32'(seen_done), 32'd0, "abort_no_done");
      check(32'(seen_busy), 32'd0, "abort_no_queued_start");

      // abort in IDLE is ignored and start is still taken
      bus.abort = 1'b1;
      run_op(3'b000, 32'd3, 32'd5, 32'd15, "abort_idle_mul");

      // asynchronous reset mid-CALC
      bus.start = 1'b1;
      bus.op    = 3'b000;
      bus.A     = 32'h1234;
      bus.B     = 32'h10;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check(32'(bus.busy), 32'd0, "async_rst_busy");
      check(32'(bus.done), 32'd0, "async_rst_done");
      check(bus.result, 32'd0, "async_rst_result");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_op(3'b000, 32'd3, 32'd4, 32'd12, "mul_after_rst");

      check(32'(sb_q.size()), 32'd0, "scoreboard_empty");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter DATA_WIDTH, 32, operand and result width; only 32 is required to be supported.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  3  operation, RV32M funct3 order: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 A  input  DATA_WIDTH  operand 1: multiplicand or dividend.
REQ-007 B  input  DATA_WIDTH  operand 2: multiplier or divisor.
REQ-008 abort  input  1  synchronous cancel of the operation in flight.
REQ-009 busy  output  1  high in CALC and FINISH.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 result  output  DATA_WIDTH  registered result; held until the next completed operation.

Function
REQ-012 States SHALL be IDLE, CALC and FINISH; no other states are reachable.
REQ-013 IDLE with start=1 at edge k SHALL latch op, A and B, load the iteration counter with 0 and enter CALC; A, B and op changes after edge k SHALL have no effect.
REQ-014 Signed operands (MULH: both; MULHSU: A only; DIV/REM: both) SHALL be converted to magnitude at latch, with result sign recorded: product sign = sA^sB, quotient sign = sA^sB, remainder sign = sA.
REQ-015 CALC SHALL perform exactly one radix-2 step per cycle: shift-add for multiply into a 2*DATA_WIDTH accumulator, restoring shift-subtract for divide.
REQ-016 CALC SHALL exit to FINISH after exactly DATA_WIDTH steps, when the counter reaches DATA_WIDTH-1.
REQ-017 FINISH SHALL apply two's-complement sign correction and select low word (MUL), high word (MULH/MULHSU/MULHU), quotient or remainder; it SHALL then load result, assert done for one cycle and return to IDLE.
REQ-018 Latency SHALL be fixed: done is high in the cycle following edge k+DATA_WIDTH+1, independent of op and operand values.
REQ-019 Divide by zero SHALL give quotient all-ones (DIV, DIVU) and remainder = A (REM, REMU), with normal latency.
REQ-020 Signed overflow (A=0x80000000, B=0xFFFFFFFF) SHALL give DIV=0x80000000 and REM=0, with normal latency.
REQ-021 start while busy=1 SHALL be ignored, with no queuing.
REQ-022 abort=1 in CALC or FINISH SHALL return to IDLE at the next edge with done=0 and result unchanged; abort in IDLE SHALL be ignored, and start is still accepted.
REQ-023 start in the cycle in which done=1 SHALL be accepted, giving back-to-back operation; done SHALL still deassert at the next edge.
REQ-024 All arithmetic SHALL be modulo 2^DATA_WIDTH on output, and intermediate widths SHALL be sized so that no step overflows.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, result=0 and clear counter and datapath registers, including mid-CALC or mid-FINISH.
REQ-026 After rst_n rises, the first start SHALL be accepted at the first rising edge with start=1.
REQ-027 An operation interrupted by reset SHALL NOT produce done.

Verification
REQ-028 MUL A=7, B=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 34 cycles after start is sampled, busy high 33 cycles.
REQ-029 A=B=0xFFFFFFFF: MULHU -> 0xFFFFFFFE, MULH -> 0x00000000, MULHSU -> 0xFFFFFFFF.
REQ-030 DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-031 DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, all at 34-cycle latency.
REQ-032 Start DIV; pulse start with new operands at cycle 5, expect them ignored; pulse abort at cycle 10, expect busy=0 next cycle, no done, and result still equal to the prior value.
REQ-033 Drive rst_n low asynchronously mid-CALC -> busy, done and result read 0 before the next clock edge; after release, MUL 3*4 -> 12.
